// File: rtl/fpadd_pipe_pkg.sv
// Shared types for the pipelined FP adder: format defaults and special-value tags
// carried alongside the datapath through the stage registers.
package fpadd_pipe_pkg;

  localparam int EXP_W_DEF = 5;
  localparam int MAN_W_DEF = 10;

  typedef enum logic [1:0] {
    SPC_NONE = 2'd0,
    SPC_INF  = 2'd1,
    SPC_NAN  = 2'd2
  } spc_e;

  typedef struct packed {
    spc_e kind;
    logic sign;
  } spc_t;

endpackage

// File: rtl/fpadd_pipe_if.sv
// Operand/result handshake bundle for fpadd_pipe; the producer/consumer side is master.
interface fpadd_pipe_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         overflow;

  modport master (output in_valid, a, b, sub, out_ready,
                  input  in_ready, out_valid, out, overflow);
  modport slave  (input  in_valid, a, b, sub, out_ready,
                  output in_ready, out_valid, out, overflow);
endinterface

// File: rtl/fpadd_pipe_lzc.sv
// Combinational leading-zero counter; all-zero input returns N.
module fpadd_pipe_lzc #(
  parameter int N  = 14,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  x,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (x[i]) cnt = CW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/fpadd_pipe.sv
// Three-stage FP adder/subtractor (align, add, normalise/round) with a single
// pipeline-wide advance enable driven by output backpressure.
module fpadd_pipe
  import fpadd_pipe_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input logic        clk,
  input logic        rst_n,
  fpadd_pipe_if.slave bus
);

  localparam int W     = EXP_W + MAN_W + 1;
  localparam int XW    = MAN_W + 4;   // hidden, mantissa, guard, round, sticky
  localparam int EW    = EXP_W + 2;   // signed exponent with headroom
  localparam int LW    = $clog2(XW + 1);
  localparam int EMAX_I = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] EMAX = '1;

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [XW-1:0]    ml;
    logic [XW-1:0]    ms;
    spc_t             spc;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic             zero_sign;
    logic [EXP_W-1:0] exp;
    logic [XW:0]      sum;
    spc_t             spc;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;

  logic         rdy_q, ov_q, ovf_q, ovf_d;
  logic [W-1:0] out_q, res_d;
  logic         adv, acc;

  assign adv           = ~ov_q | bus.out_ready;
  assign bus.in_ready  = adv & rdy_q;
  assign acc           = bus.in_valid & bus.in_ready;
  assign bus.out_valid = ov_q;
  assign bus.out       = out_q;
  assign bus.overflow  = ovf_q;

  // S1: classify, order by magnitude, align the smaller operand
  logic             sa, sb, za, zb, ia, ib, na, nb, swap;
  logic [EXP_W-1:0] ea, eb, el, es, diff;
  logic [MAN_W:0]   fa, fb, fl, fs;
  logic [XW-1:0]    ext, shf, lost_mask;

  always_comb begin
    s1_d      = '0;
    lost_mask = '0;
    shf       = '0;
    sa   = bus.a[W-1];
    sb   = bus.b[W-1] ^ bus.sub;
    ea   = bus.a[W-2:MAN_W];
    eb   = bus.b[W-2:MAN_W];
    za   = (ea == '0);
    zb   = (eb == '0);
    ia   = (ea == EMAX) && (bus.a[MAN_W-1:0] == '0);
    ib   = (eb == EMAX) && (bus.b[MAN_W-1:0] == '0);
    na   = (ea == EMAX) && (bus.a[MAN_W-1:0] != '0);
    nb   = (eb == EMAX) && (bus.b[MAN_W-1:0] != '0);
    fa   = za ? '0 : {1'b1, bus.a[MAN_W-1:0]};
    fb   = zb ? '0 : {1'b1, bus.b[MAN_W-1:0]};
    swap = {eb, fb} > {ea, fa};
    el   = swap ? eb : ea;
    es   = swap ? ea : eb;
    fl   = swap ? fb : fa;
    fs   = swap ? fa : fb;
    diff = el - es;
    ext  = {fs, 3'b000};
    if (int'(diff) >= MAN_W + 3) begin
      shf = {{(XW-1){1'b0}}, |fs};
    end else begin
      lost_mask = ~({XW{1'b1}} << diff);
      shf       = ext >> diff;
      shf[0]    = shf[0] | (|(ext & lost_mask));
    end

    s1_d.valid   = acc;
    s1_d.sign    = swap ? sb : sa;
    s1_d.eff_sub = sa ^ sb;
    s1_d.exp     = el;
    s1_d.ml      = {fl, 3'b000};
    s1_d.ms      = shf;
    if (na || nb || (ia && ib && (sa != sb))) begin
      s1_d.spc = '{kind: SPC_NAN, sign: 1'b0};
    end else if (ia) begin
      s1_d.spc = '{kind: SPC_INF, sign: sa};
    end else if (ib) begin
      s1_d.spc = '{kind: SPC_INF, sign: sb};
    end else begin
      s1_d.spc = '{kind: SPC_NONE, sign: 1'b0};
    end
  end

  // S2: magnitude add/sub; ml >= ms is guaranteed by the S1 ordering
  always_comb begin
    s2_d           = '0;
    s2_d.valid     = s1_q.valid;
    s2_d.sign      = s1_q.sign;
    s2_d.zero_sign = s1_q.eff_sub ? 1'b0 : s1_q.sign;
    s2_d.exp       = s1_q.exp;
    s2_d.spc       = s1_q.spc;
    s2_d.sum       = s1_q.eff_sub ? ({1'b0, s1_q.ml} - {1'b0, s1_q.ms})
                                  : ({1'b0, s1_q.ml} + {1'b0, s1_q.ms});
  end

  // S3: normalise, round to nearest even, pack
  logic [LW-1:0]        lz;
  logic [XW-1:0]        nrm;
  logic signed [EW-1:0] en, er;
  logic [MAN_W+1:0]     mr;
  logic [MAN_W-1:0]     man;
  logic                 rup;

  fpadd_pipe_lzc #(.N(XW), .CW(LW)) u_lzc (
    .x   (s2_q.sum[XW-1:0]),
    .cnt (lz)
  );

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    if (s2_q.sum[XW]) begin
      nrm = {s2_q.sum[XW:2], s2_q.sum[1] | s2_q.sum[0]};
      en  = EW'(s2_q.exp) + EW'(1);
    end else begin
      nrm = s2_q.sum[XW-1:0] << lz;
      en  = EW'(s2_q.exp) - EW'(lz);
    end
    rup = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    mr  = {1'b0, nrm[XW-1:3]} + (MAN_W+2)'(rup);
    if (mr[MAN_W+1]) begin
      er  = en + EW'(1);
      man = mr[MAN_W:1];
    end else begin
      er  = en;
      man = mr[MAN_W-1:0];
    end

    if (s2_q.spc.kind == SPC_NAN) begin
      res_d = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (s2_q.spc.kind == SPC_INF) begin
      res_d = {s2_q.spc.sign, EMAX, {MAN_W{1'b0}}};
    end else if (s2_q.sum == '0) begin
      res_d = {s2_q.zero_sign, {(W-1){1'b0}}};
    end else if (int'(en) <= 0) begin
      res_d = {s2_q.sign, {(W-1){1'b0}}};
    end else if (int'(er) >= EMAX_I) begin
      res_d = {s2_q.sign, EMAX, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else begin
      res_d = {s2_q.sign, er[EXP_W-1:0], man};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
      ov_q  <= 1'b0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (adv) begin
        s1_q  <= s1_d;
        s2_q  <= s2_d;
        ov_q  <= s2_q.valid;
        out_q <= res_d;
        ovf_q <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_fpadd_pipe.sv
// Scoreboard bench for fpadd_pipe (binary16): directed vectors, stall and reset flush.
module tb_fpadd_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpadd_pipe_if #(.W(16)) bus ();

  fpadd_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] out;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] o;
    logic        v;
  } vec_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] hold;

  vec_t vt [19] = '{
    '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0},
    '{16'h3E00, 16'hB800, 1'b0, 16'h3C00, 1'b0},
    '{16'h5285, 16'h9F1A, 1'b0, 16'h5285, 1'b0},
    '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1},
    '{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 1'b0},
    '{16'h4000, 16'h3C00, 1'b0, 16'h4200, 1'b0},
    '{16'h3C00, 16'h4000, 1'b1, 16'hBC00, 1'b0},
    '{16'h3C00, 16'h0001, 1'b0, 16'h3C00, 1'b0},
    '{16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 1'b0},
    '{16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 1'b0},
    '{16'h0401, 16'h0400, 1'b1, 16'h0000, 1'b0},
    '{16'h0400, 16'h0401, 1'b1, 16'h8000, 1'b0},
    '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 1'b0},
    '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 1'b0},
    '{16'h3BFF, 16'h0C00, 1'b0, 16'h3C00, 1'b0},
    '{16'h3BFF, 16'h1000, 1'b0, 16'h3C00, 1'b0},
    '{16'h3C00, 16'h0000, 1'b0, 16'h3C00, 1'b0},
    '{16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b0}
  };

  vec_t st [5] = '{
    '{16'h4000, 16'h4000, 1'b0, 16'h4400, 1'b0},
    '{16'h4400, 16'h3C00, 1'b1, 16'h4200, 1'b0},
    '{16'h3C00, 16'h3800, 1'b0, 16'h3E00, 1'b0},
    '{16'hC000, 16'hC000, 1'b0, 16'hC400, 1'b0},
    '{16'h4200, 16'hBC00, 1'b0, 16'h4000, 1'b0}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %h with no result outstanding, expected none", bus.out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("out", 32'(bus.out), 32'(e.out));
        check("overflow", 32'(bus.overflow), 32'(e.ovf));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input vec_t v);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.sub      = v.sub;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
    end else begin
      @(posedge clk);
      #1;
      sbq.push_back('{out: v.o, ovf: v.v});
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic latency_check(input string name);
    int lat = 0;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check(name, 32'(lat), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("in_ready_at_release", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("in_ready_after_release", 32'(bus.in_ready), 32'd1);

    send('{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0});
    latency_check("latency");
    drain();

    foreach (vt[i]) send(vt[i]);
    bus.in_valid = 1'b0;
    drain();

    fork
      begin
        foreach (st[i]) send(st[i]);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        hold = bus.out;
        check("stall_start_valid", 32'(bus.out_valid), 32'd1);
        repeat (4) begin
          @(negedge clk);
          check("stall_in_ready", 32'(bus.in_ready), 32'd0);
          check("stall_out_stable", 32'(bus.out), 32'(hold));
          check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    send('{16'h4000, 16'h3C00, 1'b0, 16'h4200, 1'b0});
    send('{16'h3E00, 16'hB800, 1'b0, 16'h3C00, 1'b0});
    send('{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1});
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_out", 32'(bus.out), 32'd0);
    check("async_rst_overflow", 32'(bus.overflow), 32'd0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no_stale_out", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send('{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0});
    latency_check("latency_after_reset");
    drain();

    check("queue_empty_end", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
